// File: rtl/convolutional_encoder.sv
// Rate-1/2, K=3 convolutional encoder (default generators 7,5 octal) with optional
// zero-tail termination so every frame ends in the all-zero state.
module convolutional_encoder #(
    parameter logic [2:0] G0      = 3'b111,
    parameter logic [2:0] G1      = 3'b101,
    parameter bit         TAIL_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_bit,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_valid,
    output logic [1:0] o_data,
    output logic       o_last,
    input  logic       i_ready,
    output logic       o_busy
);

    typedef enum logic {
        StData,
        StTail
    } state_e;

    state_e     state_q;
    logic       s1_q;
    logic       s2_q;
    logic       tail_cnt_q;
    logic       rst_done_q;

    logic       ld;
    logic       accept;
    logic       gen_tail;
    logic       gen;
    logic       cur;
    logic [2:0] win;
    logic [1:0] sym;

    always_comb begin
        ld       = !o_valid || i_ready;
        // Input side stays closed for the first cycle after reset release.
        o_ready  = rst_done_q && (state_q == StData) && ld;
        accept   = i_valid && o_ready;
        gen_tail = (state_q == StTail) && ld;
        gen      = accept || gen_tail;
        cur      = accept ? i_bit : 1'b0;
        win      = {cur, s1_q, s2_q};
        sym      = {^(win & G0), ^(win & G1)};
        o_busy   = (state_q == StTail) || o_valid;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StData;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            tail_cnt_q <= 1'b0;
            rst_done_q <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= 2'b00;
            o_last     <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (gen) begin
                o_valid <= 1'b1;
                o_data  <= sym;
                o_last  <= 1'b0;
                s1_q    <= cur;
                s2_q    <= s1_q;
                if (gen_tail) begin
                    tail_cnt_q <= 1'b1;
                    // Two zero shifts have flushed the register; no explicit clear needed.
                    if (tail_cnt_q) begin
                        o_last     <= 1'b1;
                        state_q    <= StData;
                        tail_cnt_q <= 1'b0;
                    end
                end else if (i_last) begin
                    if (TAIL_EN) begin
                        state_q    <= StTail;
                        tail_cnt_q <= 1'b0;
                    end else begin
                        o_last <= 1'b1;
                        s1_q   <= 1'b0;
                        s2_q   <= 1'b0;
                    end
                end
            end else if (i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_convolutional_encoder.sv
// Directed and randomized checks of the K=3 encoder: one instance with zero tail,
// one without; symbols are collected at the output handshake and compared to hand values.
module tb_convolutional_encoder;

    typedef struct {
        int unsigned dut;
        int unsigned nbits;
        logic [7:0]  bits;
        int unsigned nsym;
        logic [15:0] syms;
        logic [7:0]  lasts;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_valid = 1'b0;
    logic i_bit = 1'b0;
    logic i_last = 1'b0;
    logic rdy_man = 1'b1;
    logic rdy_rand = 1'b1;
    int   rdy_idx = 0;
    int   rmode = 0;
    int   sel = 0;
    logic i_ready;
    logic valid_a, valid_b;

    logic       o_ready_a, o_valid_a, o_last_a, o_busy_a;
    logic [1:0] o_data_a;
    logic       o_ready_b, o_valid_b, o_last_b, o_busy_b;
    logic [1:0] o_data_b;
    logic       cur_ready;

    int n_tests = 0;
    int n_fail = 0;

    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic [2:0] exp_q[$];
    logic       held_a;
    logic [2:0] prev_a;

    vec_t       vecs[7];
    logic [1:0] ce_exp[6];
    logic [3:0] ce_bits;

    assign i_ready = (rmode == 0) ? rdy_man :
                     (rmode == 1) ? ((rdy_idx % 4 == 0) || (rdy_idx % 4 == 3)) : rdy_rand;
    assign valid_a   = i_valid && (sel == 0);
    assign valid_b   = i_valid && (sel == 1);
    assign cur_ready = (sel == 1) ? o_ready_b : o_ready_a;

    convolutional_encoder dut_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (valid_a),
        .i_bit   (i_bit),
        .i_last  (i_last),
        .o_ready (o_ready_a),
        .o_valid (o_valid_a),
        .o_data  (o_data_a),
        .o_last  (o_last_a),
        .i_ready (i_ready),
        .o_busy  (o_busy_a)
    );

    convolutional_encoder #(.TAIL_EN(1'b0)) dut_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (valid_b),
        .i_bit   (i_bit),
        .i_last  (i_last),
        .o_ready (o_ready_b),
        .o_valid (o_valid_b),
        .o_data  (o_data_b),
        .o_last  (o_last_b),
        .i_ready (i_ready),
        .o_busy  (o_busy_b)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference (7,5) encoder: parity0 taps cur,m1,m2; parity1 taps cur,m2.
    function automatic logic [1:0] enc(input logic b, input logic m1, input logic m2);
        return {b ^ m1 ^ m2, b ^ m2};
    endfunction

    function automatic int qsz(input int d);
        return (d == 1) ? qb.size() : qa.size();
    endfunction

    // Output monitor for A: collect handshaken symbols and check hold under backpressure.
    initial begin
        held_a = 1'b0;
        prev_a = 3'b000;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                held_a = 1'b0;
            end else begin
                if (held_a)
                    check("hold_a", {29'd0, o_valid_a, o_last_a, o_data_a}, {28'd0, 1'b1, prev_a});
                if (o_valid_a && i_ready) qa.push_back({o_last_a, o_data_a});
                held_a = o_valid_a && !i_ready;
                prev_a = {o_last_a, o_data_a};
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_valid_b && i_ready) qb.push_back({o_last_b, o_data_b});
        end
    end

    // Pattern / random ready generator, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            rdy_idx++;
            rdy_rand = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, input logic l);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        i_valid = 1'b1;
        i_bit = b;
        i_last = l;
        while (!done) begin
            @(negedge i_clk);
            if (cur_ready) done = 1'b1;
            @(posedge i_clk);
            #1;
            n++;
            if (!done && n > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        i_valid = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string name);
        int n;
        logic [2:0] got;
        if (v.dut == 1) qb.delete();
        else qa.delete();
        sel = v.dut;
        for (int i = 0; i < v.nbits; i++) send_bit(v.bits[i], (i == v.nbits - 1));
        n = 0;
        while (qsz(v.dut) < v.nsym && n < 200) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        repeat (6) @(posedge i_clk);
        #1;
        check({name, " count"}, qsz(v.dut), v.nsym);
        for (int i = 0; i < v.nsym; i++) begin
            got = 3'bxxx;
            if (i < qsz(v.dut)) got = (v.dut == 1) ? qb[i] : qa[i];
            check($sformatf("%s sym%0d", name, i), {29'd0, got},
                  {29'd0, v.lasts[i], v.syms[2*i +: 2]});
        end
    endtask

    initial begin
        int   nbits;
        int   len;
        int   n;
        logic b;
        logic l;
        logic m1;
        logic m2;
        logic [2:0] got;

        vecs[0] = '{0, 4, 8'b0000_1101, 6, 16'b00_00_11_01_01_00_10_11, 8'b0010_0000};
        vecs[1] = '{0, 1, 8'b0000_0001, 3, 16'b00_00_00_00_00_11_10_11, 8'b0000_0100};
        vecs[2] = '{0, 1, 8'b0000_0001, 3, 16'b00_00_00_00_00_11_10_11, 8'b0000_0100};
        vecs[3] = '{1, 2, 8'b0000_0011, 2, 16'b00_00_00_00_00_00_01_11, 8'b0000_0010};
        vecs[4] = '{1, 1, 8'b0000_0001, 1, 16'b00_00_00_00_00_00_00_11, 8'b0000_0001};
        vecs[5] = '{0, 5, 8'b0000_0110, 7, 16'b00_00_00_11_01_01_11_00, 8'b0100_0000};
        vecs[6] = '{1, 2, 8'b0000_0001, 2, 16'b00_00_00_00_00_00_10_11, 8'b0000_0010};
        ce_exp  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        ce_bits = 4'b1101;

        // Reset values
        repeat (2) @(posedge i_clk);
        #1;
        check("rst o_valid", {31'd0, o_valid_a}, 32'd0);
        check("rst o_data", {30'd0, o_data_a}, 32'd0);
        check("rst o_last", {31'd0, o_last_a}, 32'd0);
        check("rst o_busy", {31'd0, o_busy_a}, 32'd0);
        check("rst o_ready", {31'd0, o_ready_a}, 32'd0);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("post-rst o_ready", {31'd0, o_ready_a}, 32'd1);

        // Cycle-exact 1,0,1,1 frame with i_ready held high
        sel = 0;
        i_valid = 1'b1;
        i_bit = ce_bits[0];
        i_last = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            check($sformatf("ce ready c%0d", c), {31'd0, o_ready_a},
                  (c == 4 || c == 5) ? 32'd0 : 32'd1);
            check($sformatf("ce valid c%0d", c), {31'd0, o_valid_a},
                  (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 6) begin
                check($sformatf("ce data c%0d", c), {30'd0, o_data_a}, {30'd0, ce_exp[c-1]});
                check($sformatf("ce last c%0d", c), {31'd0, o_last_a},
                      (c == 6) ? 32'd1 : 32'd0);
            end
            @(posedge i_clk);
            #1;
            if (c + 1 < 4) begin
                i_bit = ce_bits[c+1];
                i_last = (c + 1 == 3);
            end else begin
                i_valid = 1'b0;
                i_last = 1'b0;
            end
        end

        for (int k = 0; k < 7; k++) apply(vecs[k], $sformatf("vec%0d", k));

        // Backpressure: ready pattern 1,0,0,1,...
        rmode = 1;
        apply(vecs[0], "bp");
        rmode = 0;
        rdy_man = 1'b1;

        // Reset in the middle of a frame
        sel = 0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("midrst pre valid", {31'd0, o_valid_a}, 32'd1);
        i_rst = 1'b1;
        #1;
        check("midrst valid", {31'd0, o_valid_a}, 32'd0);
        check("midrst busy", {31'd0, o_busy_a}, 32'd0);
        check("midrst ready", {31'd0, o_ready_a}, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        apply('{0, 1, 8'b0000_0000, 3, 16'h0000, 8'b0000_0100}, "rst frame");

        // Random frames with random valid gaps and ready
        rmode = 2;
        sel = 0;
        qa.delete();
        exp_q.delete();
        m1 = 1'b0;
        m2 = 1'b0;
        nbits = 0;
        while (nbits < 1000) begin
            len = $urandom_range(1, 8);
            if (len > 1000 - nbits) len = 1000 - nbits;
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge i_clk);
                    #1;
                end
                b = ($urandom_range(0, 1) == 1);
                l = (k == len - 1);
                send_bit(b, l);
                exp_q.push_back({1'b0, enc(b, m1, m2)});
                m2 = m1;
                m1 = b;
                if (l) begin
                    exp_q.push_back({1'b0, enc(1'b0, m1, m2)});
                    m2 = m1;
                    m1 = 1'b0;
                    exp_q.push_back({1'b1, enc(1'b0, m1, m2)});
                    m1 = 1'b0;
                    m2 = 1'b0;
                end
                nbits++;
            end
        end
        n = 0;
        while (qa.size() < exp_q.size() && n < 500) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        rmode = 0;
        repeat (4) @(posedge i_clk);
        #1;
        check("rand count", qa.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < qa.size()) ? qa[i] : 3'bxxx;
            check($sformatf("rand sym%0d", i), {29'd0, got}, {29'd0, exp_q[i]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
